baccarat_round_ctrl: RTL

- Round sequencer for the Baccarat engine.
- Fetches cards from an external card source over a req/valid handshake and steers each card into one of six card registers via one-hot load strobes.
- Reads the player and dealer hand scores produced by the scorehand datapath and applies the third-card rules.
- Registers the round outcome.
- Sits between the card source/shuffler and the card-register + scoring datapath.

---
 rtl/baccarat_pkg.sv | 35 +++
 rtl/dealer_draw_rule.sv | 27 ++
 rtl/baccarat_round_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the Baccarat round sequencer.
// Optional outcome tallies are enabled with the BACCARAT_TALLY_EN macro.
package baccarat_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DP1,
      S_DD1,
      S_DP2,
      S_DD2,
      S_EVAL,
      S_DP3,
      S_EVALB,
      S_DD3,
      S_CMP,
      S_DONE
   } state_t;

   localparam int LOAD_PCARD1 = 0;
   localparam int LOAD_PCARD2 = 1;
   localparam int LOAD_PCARD3 = 2;
   localparam int LOAD_DCARD1 = 3;
   localparam int LOAD_DCARD2 = 4;
   localparam int LOAD_DCARD3 = 5;

   localparam logic [3:0] CARD_MIN = 4'd1;
   localparam logic [3:0] CARD_MAX = 4'd13;
   localparam logic [3:0] NATURAL  = 4'd8;

   // Face cards and tens count as zero towards a hand score.
   function automatic logic [3:0] card_value(input logic [3:0] rank);
      return (rank > 4'd9) ? 4'd0 : rank;
   endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card rule: decides whether the dealer draws, given the dealer
// two-card score and the rank of the player's third card.
module dealer_draw_rule
   import baccarat_pkg::*;
(
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       draw
);

   logic [3:0] w_v;

   assign w_v = card_value(pcard3);

   always_comb begin
      draw = 1'b0;
      case (dscore)
         4'd0, 4'd1, 4'd2: draw = 1'b1;
         4'd3:             draw = (w_v != 4'd8);
         4'd4:             draw = (w_v >= 4'd2) && (w_v <= 4'd7);
         4'd5:             draw = (w_v >= 4'd4) && (w_v <= 4'd7);
         4'd6:             draw = (w_v >= 4'd6) && (w_v <= 4'd7);
         default:          draw = 1'b0;
      endcase
   end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals cards, applies third-card rules, registers
// the outcome. Define BACCARAT_TALLY_EN to add saturating outcome counters.
module baccarat_round_ctrl
   import baccarat_pkg::*;
`ifdef BACCARAT_TALLY_EN
#(
   parameter int TALLY_W = 8
)
`endif
(
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       start,
   output logic       card_req,
   input  logic       card_valid,
   input  logic [3:0] card_in,
   output logic [5:0] load_sel,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       busy,
   output logic       done,
   output logic       player_win,
   output logic       dealer_win
`ifdef BACCARAT_TALLY_EN
   ,
   output logic [TALLY_W-1:0] tally_player,
   output logic [TALLY_W-1:0] tally_dealer,
   output logic [TALLY_W-1:0] tally_tie
`endif
);

   state_t r_state;
   state_t w_next;
   logic   w_cardOk;
   logic   w_draw;
   logic   r_playerWin;
   logic   r_dealerWin;

   assign w_cardOk = card_valid && (card_in >= CARD_MIN) && (card_in <= CARD_MAX);

   dealer_draw_rule u_rule (
      .dscore (dscore),
      .pcard3 (pcard3),
      .draw   (w_draw)
   );

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Strobes are decoded from state so they vanish as soon as reset lands.
   always_comb begin
      w_next   = r_state;
      card_req = 1'b0;
      load_sel = '0;
      busy     = 1'b1;
      done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_DP1;
         end
         S_DP1: begin
            card_req = 1'b1;
            if (w_cardOk) begin
               load_sel[LOAD_PCARD1] = 1'b1;
               w_next = S_DD1;
            end
         end
         S_DD1: begin
            card_req = 1'b1;
            if (w_cardOk) begin
               load_sel[LOAD_DCARD1] = 1'b1;
               w_next = S_DP2;
            end
         end
         S_DP2: begin
            card_req = 1'b1;
            if (w_cardOk) begin
               load_sel[LOAD_PCARD2] = 1'b1;
               w_next = S_DD2;
            end
         end
         S_DD2: begin
            card_req = 1'b1;
            if (w_cardOk) begin
               load_sel[LOAD_DCARD2] = 1'b1;
               w_next = S_EVAL;
            end
         end
         S_EVAL: begin
            if ((pscore >= NATURAL) || (dscore >= NATURAL)) w_next = S_CMP;
            else if (pscore <= 4'd5)                         w_next = S_DP3;
            else if (dscore <= 4'd5)                         w_next = S_DD3;
            else                                             w_next = S_CMP;
         end
         S_DP3: begin
            card_req = 1'b1;
            if (w_cardOk) begin
               load_sel[LOAD_PCARD3] = 1'b1;
               w_next = S_EVALB;
            end
         end
         S_EVALB: w_next = w_draw ? S_DD3 : S_CMP;
         S_DD3: begin
            card_req = 1'b1;
            if (w_cardOk) begin
               load_sel[LOAD_DCARD3] = 1'b1;
               w_next = S_CMP;
            end
         end
         S_CMP: w_next = S_DONE;
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) w_next = S_DP1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Equal scores set both flags, which is how a tie is reported.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         r_playerWin <= 1'b0;
         r_dealerWin <= 1'b0;
      end else if (r_state == S_CMP) begin
         r_playerWin <= (pscore >= dscore);
         r_dealerWin <= (dscore >= pscore);
      end else if ((r_state == S_DONE) && start) begin
         r_playerWin <= 1'b0;
         r_dealerWin <= 1'b0;
      end
   end

   assign player_win = r_playerWin;
   assign dealer_win = r_dealerWin;

`ifdef BACCARAT_TALLY_EN
   localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

   logic [TALLY_W-1:0] r_tallyPlayer;
   logic [TALLY_W-1:0] r_tallyDealer;
   logic [TALLY_W-1:0] r_tallyTie;

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         r_tallyPlayer <= '0;
         r_tallyDealer <= '0;
         r_tallyTie    <= '0;
      end else if (r_state == S_CMP) begin
         if (pscore == dscore) begin
            if (r_tallyTie != TALLY_MAX) r_tallyTie <= r_tallyTie + 1'b1;
         end else if (pscore > dscore) begin
            if (r_tallyPlayer != TALLY_MAX) r_tallyPlayer <= r_tallyPlayer + 1'b1;
         end else begin
            if (r_tallyDealer != TALLY_MAX) r_tallyDealer <= r_tallyDealer + 1'b1;
         end
      end
   end

   assign tally_player = r_tallyPlayer;
   assign tally_dealer = r_tallyDealer;
   assign tally_tie    = r_tallyTie;
`endif

endmodule
